systolic_skew_feeder: RTL and testbench
=======================================

# systolic_skew_feeder

Operand feeder for the N×N output-stationary systolic array of multiply-accumulate PEs. It stores one A matrix and one B matrix written over a simple write port. On `start` it drives the array's left edge (A rows) and top edge (B columns) with the diagonally skewed, zero-padded operand wavefront the PEs expect. It then holds for the drain period and reports `done` once every PE accumulator holds its final C[i][j].

## Interface
Parameters:
- `N`, 4, array dimension; matrices are N×N, N ≥ 2
- `REG_WIDTH`, 4, operand width; matches the PE `REG_WIDTH`
- `CNT_WIDTH`, 4, step counter width; must satisfy 2^CNT_WIDTH ≥ 2N-1

Ports:
- `clk`  in  1  single clock; all logic on the rising edge
- `reset`  in  1  synchronous, active-high
- `wr_en`  in  1  write strobe for the operand memory
- `wr_sel`  in  1  0 = write A, 1 = write B
- `wr_row`  in  $clog2(N)  row index
- `wr_col`  in  $clog2(N)  column index
- `wr_data`  in  REG_WIDTH  element value
- `start`  in  1  single-cycle request to run one multiply
- `busy`  out  1  high in CLEAR, FEED, DRAIN and DONE
- `done`  out  1  one-cycle pulse in DONE
- `pe_reset`  out  1  clears the array's accumulators and pipeline registers
- `a_out`  out  N*REG_WIDTH  slice i = A operand into row i, PE(i,0)
- `b_out`  out  N*REG_WIDTH  slice j = B operand into column j, PE(0,j)

## Operation
- Storage: two N×N register arrays, A[i][k] and B[k][j].
  - A write with `wr_sel`=0 stores A[wr_row][wr_col]; with `wr_sel`=1 it stores B[wr_row][wr_col].
  - Writes are accepted only in IDLE and are ignored in every other state.
- State machine: IDLE → CLEAR → FEED → DRAIN → DONE → IDLE.
  - IDLE: outputs are zero. `start`=1 moves to CLEAR. `start` in any other state is ignored.
  - CLEAR: exactly one cycle with `pe_reset`=1 and operand outputs zero.
  - FEED: runs for 2N-1 cycles, step counter t = 0 … 2N-2.
    - a_out slice i = A[i][t-i] when 0 ≤ t-i < N, else 0.
    - b_out slice j = B[t-j][j] when 0 ≤ t-j < N, else 0.
  - DRAIN: N-1 cycles with all operand outputs zero, so that PE(N-1,N-1) completes its last MAC.
  - DONE: one cycle with `done`=1; all operand outputs remain zero.
- All outputs are registered: the value stated for a state or step is present during that cycle.
- Arithmetic: the feeder performs no arithmetic on data. Each PE result is sum over k of A[i][k]·B[k][j], wrapping modulo 2^OUT_WIDTH inside the PE.
- Reset: takes effect from any state, including mid-FEED.
  - Next state is IDLE; `busy`, `done`, `pe_reset`, `a_out` and `b_out` are all 0.
  - All A and B storage is cleared to 0; the step counter is cleared to 0.
- Simultaneous `reset` and `start`, or `reset` and `wr_en`: reset wins; nothing is written and no run starts.
- Simultaneous `start` and `wr_en` in IDLE: the write is performed and the run uses the newly written value.

## Timing
- `start` is sampled at edge 0. With auto-clear compiled in:
  - CLEAR is cycle 1.
  - FEED is cycles 2 … 2N.
  - DRAIN is cycles 2N+1 … 3N-1.
  - DONE is cycle 3N.
  - IDLE from cycle 3N+1.
- Total latency from `start` to `done` is 3N cycles (12 for N=4).
- Without auto-clear, every phase moves one cycle earlier and latency is 3N-1.
- Back-to-back runs: the earliest a new `start` is accepted is the cycle after DONE.

## Configuration
- Macro `SKEW_FEEDER_AUTO_CLEAR_EN`.
- Defined:
  - the CLEAR state exists;
  - `pe_reset` pulses once per run, so every run produces a fresh product.
- Undefined:
  - the CLEAR state is removed (IDLE goes straight to FEED);
  - `pe_reset` is tied to 0;
  - consecutive runs accumulate, giving C += A·B.

## Test plan
All scenarios use N=4, REG_WIDTH=4, PE OUT_WIDTH=8 and auto-clear defined unless stated.
- Identity times B: write A=I and B[k][j]=4k+j, then pulse `start` → `done` exactly 12 cycles after `start`, and array C[i][j]=4i+j.
- Skew check: A[i][k]=i+1, B all 1s → in FEED step t=3, a_out slices are (1,2,3,4) and b_out slices all 1. At t=0 only slice 0 is nonzero. At t=6 only slice 3 is nonzero.
- Overflow wrap: all elements 15 → every C = 900 mod 256 = 132.
- Reset mid-FEED: assert `reset` at FEED step 2 → next cycle IDLE, all outputs 0. A later read-back via a run with no writes yields all C = 0.
- Writes during busy: `wr_en` with A[0][0]=9 during FEED → ignored. The current run and a second run both use the original A[0][0].
- Macro undefined: run A=I, B=I twice → no `pe_reset` pulse, latency 11 cycles, diagonal C = 2 after the second run.

Source files
------------

// File: rtl/systolic_skew_feeder_if.sv
// systolic_skew_feeder_if: write port, run control and array-edge operand bus
// between the operand feeder and its driver.
interface systolic_skew_feeder_if #(
    parameter int N         = 4,
    parameter int REG_WIDTH = 4
);
    localparam int IW = $clog2(N);

    logic                   wr_en;
    logic                   wr_sel;
    logic [IW-1:0]          wr_row;
    logic [IW-1:0]          wr_col;
    logic [REG_WIDTH-1:0]   wr_data;
    logic                   start;
    logic                   busy;
    logic                   done;
    logic                   pe_reset;
    logic [N*REG_WIDTH-1:0] a_out;
    logic [N*REG_WIDTH-1:0] b_out;

    modport master (
        output wr_en, wr_sel, wr_row, wr_col, wr_data, start,
        input  busy, done, pe_reset, a_out, b_out
    );

    modport slave (
        input  wr_en, wr_sel, wr_row, wr_col, wr_data, start,
        output busy, done, pe_reset, a_out, b_out
    );
endinterface

// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder: stores A and B, drives the skewed operand wavefront.
// Macro SKEW_FEEDER_AUTO_CLEAR_EN adds a CLEAR state pulsing pe_reset.
module systolic_skew_feeder #(
    parameter int N         = 4,
    parameter int REG_WIDTH = 4,
    parameter int CNT_WIDTH = 4
) (
    input logic                   clk,
    input logic                   reset,
    systolic_skew_feeder_if.slave bus
);
    localparam logic [CNT_WIDTH-1:0] FEED_LAST  = CNT_WIDTH'(2 * N - 2);
    localparam logic [CNT_WIDTH-1:0] DRAIN_LAST = CNT_WIDTH'(N - 2);

    typedef enum logic [2:0] {
        IDLE,
`ifdef SKEW_FEEDER_AUTO_CLEAR_EN
        CLEAR,
`endif
        FEED,
        DRAIN,
        DONE
    } state_t;

    state_t                 state;
    state_t                 state_n;
    logic [CNT_WIDTH-1:0]   cnt;
    logic [CNT_WIDTH-1:0]   cnt_n;

    logic [REG_WIDTH-1:0]   a_mem [N][N];
    logic [REG_WIDTH-1:0]   b_mem [N][N];
    logic [REG_WIDTH-1:0]   a_nx  [N][N];
    logic [REG_WIDTH-1:0]   b_nx  [N][N];

    logic [N*REG_WIDTH-1:0] a_n;
    logic [N*REG_WIDTH-1:0] b_n;
    logic [N*REG_WIDTH-1:0] a_q;
    logic [N*REG_WIDTH-1:0] b_q;
    logic                   busy_q;
    logic                   done_q;

    // Memory view after this cycle's write, so a run started alongside a write sees it
    always_comb begin
        a_nx = a_mem;
        b_nx = b_mem;
        if (state == IDLE && bus.wr_en) begin
            if (bus.wr_sel) begin
                b_nx[bus.wr_row][bus.wr_col] = bus.wr_data;
            end else begin
                a_nx[bus.wr_row][bus.wr_col] = bus.wr_data;
            end
        end
    end

    // Operand storage; cleared by reset, written only in IDLE
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < N; k++) begin
                    a_mem[i][k] <= '0;
                    b_mem[i][k] <= '0;
                end
            end
        end else begin
            a_mem <= a_nx;
            b_mem <= b_nx;
        end
    end

    // Next state and step counter
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (bus.start) begin
`ifdef SKEW_FEEDER_AUTO_CLEAR_EN
                    state_n = CLEAR;
`else
                    state_n = FEED;
`endif
                end
            end
`ifdef SKEW_FEEDER_AUTO_CLEAR_EN
            CLEAR: begin
                state_n = FEED;
                cnt_n   = '0;
            end
`endif
            FEED: begin
                if (cnt == FEED_LAST) begin
                    state_n = DRAIN;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DRAIN: begin
                if (cnt == DRAIN_LAST) begin
                    state_n = DONE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Wavefront for the upcoming cycle: row i gets A[i][t-i], column j gets B[t-j][j]
    always_comb begin
        a_n = '0;
        b_n = '0;
        if (state_n == FEED) begin
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < N; k++) begin
                    if (int'(cnt_n) == i + k) begin
                        a_n[i*REG_WIDTH +: REG_WIDTH] = a_nx[i][k];
                        b_n[i*REG_WIDTH +: REG_WIDTH] = b_nx[k][i];
                    end
                end
            end
        end
    end

    // State, counter and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            busy_q <= (state_n != IDLE);
            done_q <= (state_n == DONE);
            a_q    <= a_n;
            b_q    <= b_n;
        end
    end

`ifdef SKEW_FEEDER_AUTO_CLEAR_EN
    logic pe_reset_q;

    // One array clear per run, during CLEAR
    always_ff @(posedge clk) begin
        if (reset) begin
            pe_reset_q <= 1'b0;
        end else begin
            pe_reset_q <= (state_n == CLEAR);
        end
    end

    assign bus.pe_reset = pe_reset_q;
`else
    assign bus.pe_reset = 1'b0;
`endif

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.a_out = a_q;
    assign bus.b_out = b_q;
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// tb_systolic_skew_feeder: directed runs with a per-cycle output scoreboard
// and a behavioural output-stationary PE array checking the final C.
module tb_systolic_skew_feeder;
    localparam int N  = 4;
    localparam int RW = 4;
    localparam int VW = 3 + 2 * N * RW;
`ifdef SKEW_FEEDER_AUTO_CLEAR_EN
    localparam int AC = 1;
`else
    localparam int AC = 0;
`endif
    localparam int LAT = 3 * N - 1 + AC;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    int         am [N][N];
    int         bm [N][N];
    logic [7:0] exp_c [N][N];
    logic [VW-1:0] sb [$];

    systolic_skew_feeder_if #(.N(N), .REG_WIDTH(RW)) bus ();

    systolic_skew_feeder #(.N(N), .REG_WIDTH(RW), .CNT_WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural PE array, 8-bit accumulators
    logic [RW-1:0] pa  [N][N];
    logic [RW-1:0] pb  [N][N];
    logic [7:0]    acc [N][N];

    function automatic logic [RW-1:0] a_in(int i, int j);
        if (j == 0) return bus.a_out[i*RW +: RW];
        return pa[i][j-1];
    endfunction

    function automatic logic [RW-1:0] b_in(int i, int j);
        if (i == 0) return bus.b_out[j*RW +: RW];
        return pb[i-1][j];
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (reset || bus.pe_reset) begin
                    pa[i][j]  <= '0;
                    pb[i][j]  <= '0;
                    acc[i][j] <= '0;
                end else begin
                    pa[i][j]  <= a_in(i, j);
                    pb[i][j]  <= b_in(i, j);
                    acc[i][j] <= acc[i][j] + 8'(a_in(i, j)) * 8'(b_in(i, j));
                end
            end
        end
    end

    function automatic logic [VW-1:0] obs_vec();
        return {bus.busy, bus.done, bus.pe_reset, bus.a_out, bus.b_out};
    endfunction

    function automatic logic [VW-1:0] exp_vec(int c);
        logic          bz;
        logic          dn;
        logic          pr;
        logic [N*RW-1:0] a;
        logic [N*RW-1:0] b;
        int            t;
        int            d;
        bz = (c >= 1 && c <= LAT);
        dn = (c == LAT);
        pr = (AC == 1 && c == 1);
        a  = '0;
        b  = '0;
        t  = c - 1 - AC;
        if (t >= 0 && t <= 2 * N - 2) begin
            for (int i = 0; i < N; i++) begin
                d = t - i;
                if (d >= 0 && d < N) a[i*RW +: RW] = RW'(am[i][d]);
            end
            for (int j = 0; j < N; j++) begin
                d = t - j;
                if (d >= 0 && d < N) b[j*RW +: RW] = RW'(bm[d][j]);
            end
        end
        return {bz, dn, pr, a, b};
    endfunction

    task automatic chk(input string tag, input logic [VW-1:0] o, input logic [VW-1:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                am[i][j]    = 0;
                bm[i][j]    = 0;
                exp_c[i][j] = '0;
            end
        end
    endtask

    task automatic wr(input bit sel, input int r, input int c, input int d);
        bus.wr_en   = 1'b1;
        bus.wr_sel  = sel;
        bus.wr_row  = 2'(r);
        bus.wr_col  = 2'(c);
        bus.wr_data = RW'(d);
        if (sel) bm[r][c] = d;
        else     am[r][c] = d;
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    // Starts at a negedge in IDLE; ends at the negedge of the IDLE cycle after DONE
    task automatic run(input string name, input int inj_c, input int rst_c);
        int s;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                s = 0;
                for (int k = 0; k < N; k++) s += am[i][k] * bm[k][j];
                if (AC == 1) exp_c[i][j] = 8'(s);
                else         exp_c[i][j] = 8'(int'(exp_c[i][j]) + s);
            end
        end
        for (int c = 1; c <= LAT + 1; c++) sb.push_back(exp_vec(c));
        bus.start = 1'b1;
        for (int c = 1; c <= LAT + 1; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.wr_en = 1'b0;
            chk($sformatf("%s_cyc%0d", name, c), obs_vec(), sb.pop_front());
            if (c == inj_c) begin
                bus.wr_en   = 1'b1;
                bus.wr_sel  = 1'b0;
                bus.wr_row  = 2'd0;
                bus.wr_col  = 2'd0;
                bus.wr_data = 4'd9;
            end
            if (c == rst_c) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                chk({name, "_after_reset"}, obs_vec(), '0);
                sb.delete();
                clear_model();
                return;
            end
        end
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                chk($sformatf("%s_c%0d%0d", name, i, j), VW'(acc[i][j]), VW'(exp_c[i][j]));
            end
        end
    endtask

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_sel  = 1'b0;
        bus.wr_row  = '0;
        bus.wr_col  = '0;
        bus.wr_data = '0;
        bus.start   = 1'b0;
        reset       = 1'b1;
        clear_model();
        repeat (2) @(negedge clk);
        chk("reset_state", obs_vec(), '0);
        reset = 1'b0;
        @(negedge clk);

        // A = I, B[k][j] = 4k+j; B[3][3] written in the same cycle as start
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) wr(1'b0, i, k, (i == k) ? 1 : 0);
        for (int k = 0; k < N; k++)
            for (int j = 0; j < N; j++)
                if (!(k == 3 && j == 3)) wr(1'b1, k, j, 4 * k + j);
        bus.wr_en   = 1'b1;
        bus.wr_sel  = 1'b1;
        bus.wr_row  = 2'd3;
        bus.wr_col  = 2'd3;
        bus.wr_data = 4'd15;
        bm[3][3]    = 15;
        run("ident", -1, -1);

        // Skew pattern: A[i][k] = i+1, B all ones
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) begin
                wr(1'b0, i, k, i + 1);
                wr(1'b1, i, k, 1);
            end
        run("skew", -1, -1);

        // Wraparound: every element 15
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) begin
                wr(1'b0, i, k, 15);
                wr(1'b1, i, k, 15);
            end
        run("wrap", -1, -1);

        // Reset at FEED step 2
        run("midrst", -1, AC + 3);

        // Reset beats a coincident start and write
        bus.start   = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_sel  = 1'b0;
        bus.wr_row  = 2'd1;
        bus.wr_col  = 2'd1;
        bus.wr_data = 4'd5;
        reset       = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        chk("reset_vs_start", obs_vec(), '0);
        @(negedge clk);
        chk("reset_vs_start_idle", obs_vec(), '0);
        run("cleared", -1, -1);

        // Writes while busy are dropped; back-to-back second run
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) begin
                wr(1'b0, i, k, k + 1);
                wr(1'b1, i, k, (i + 2 * k) % 16);
            end
        run("busywr1", AC + 2, -1);
        run("busywr2", -1, -1);

        // A = I, B = I twice
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) begin
                wr(1'b0, i, k, (i == k) ? 1 : 0);
                wr(1'b1, i, k, (i == k) ? 1 : 0);
            end
        run("eye1", -1, -1);
        run("eye2", -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
